// File: rtl/cpu_pkg.sv
// Shared CPU-side types for the register-file port arbiter.
// Holds the arbiter state encoding and the default RF geometry.
package cpu_pkg;

  localparam int DEF_DATA_W     = 8;
  localparam int DEF_ADDR_W     = 3;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_ACK,
    RD_A,
    RD_B,
    RD_CAP,
    RD_ACK
  } arb_state_t;

endpackage

// File: rtl/regfile_port_arbiter.sv
// Shares the single RF port between ID operand reads and WB writes (writes preferred,
// reads forced after STARVE_MAX writes). Define RF_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_port_arbiter
  import cpu_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clk_regfile,
  input  logic              reset_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              rd_ack,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic              rf_en,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_MAX);

`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  arb_state_t        state_q, state_d;
  logic [CNT_W-1:0]  starve_q;
  logic [ADDR_W-1:0] addr_a_q, addr_b_q, wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              rd_pend, wr_pend, wr_suppress;

  function automatic logic [DATA_W-1:0] capture(input logic [ADDR_W-1:0] a,
                                                input logic [DATA_W-1:0] d);
    return (ZERO_REG && a == '0) ? '0 : d;
  endfunction

  assign rd_pend     = rd_req && !rd_ack;
  assign wr_pend     = wr_req && !wr_ack;
  assign wr_suppress = ZERO_REG && (wr_addr_q == '0);

  // Request fields are snapshotted while idle so the RF outputs depend on flops only.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_regfile or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      starve_q  <= '0;
      addr_a_q  <= '0;
      addr_b_q  <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rd_data_a <= '0;
      rd_data_b <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        addr_a_q  <= rd_addr_a;
        addr_b_q  <= rd_addr_b;
        wr_addr_q <= wr_addr;
        wr_data_q <= wr_data;
      end
      case (state_q)
        WR:      if (rd_req && starve_q != STARVE_TOP) starve_q <= starve_q + 1'b1;
        RD_B:    rd_data_a <= capture(addr_a_q, rf_rdata);
        RD_CAP: begin
          rd_data_b <= capture(addr_b_q, rf_rdata);
          starve_q  <= '0;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    state_d  = state_q;
    rf_en    = 1'b0;
    rf_we    = 1'b0;
    rf_addr  = '0;
    rf_wdata = '0;
    wr_ack   = 1'b0;
    rd_ack   = 1'b0;
    busy     = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (wr_req && !(rd_req && starve_q == STARVE_TOP)) state_d = WR;
        else if (rd_req)                                   state_d = RD_A;
      end
      WR: begin
        if (!wr_suppress) begin
          rf_en    = 1'b1;
          rf_we    = 1'b1;
          rf_addr  = wr_addr_q;
          rf_wdata = wr_data_q;
        end
        state_d = WR_ACK;
      end
      WR_ACK: begin
        wr_ack = 1'b1;
        if (!wr_req) state_d = IDLE;
      end
      RD_A: begin
        rf_en   = 1'b1;
        rf_addr = addr_a_q;
        state_d = RD_B;
      end
      RD_B: begin
        rf_en   = 1'b1;
        rf_addr = addr_b_q;
        state_d = RD_CAP;
      end
      RD_CAP: state_d = RD_ACK;
      RD_ACK: begin
        rd_ack = 1'b1;
        if (!rd_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Acks are low in IDLE, so pending reduces to req there; kept explicit for clarity.
    if (state_q == IDLE) begin
      if (wr_pend && !(rd_pend && starve_q == STARVE_TOP)) state_d = WR;
      else if (rd_pend)                                    state_d = RD_A;
      else                                                 state_d = IDLE;
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Self-checking bench for regfile_port_arbiter: directed steps plus random traffic
// checked against a shadow register file and a transaction-level starvation rule.
module tb_regfile_port_arbiter;

  localparam int STARVE_MAX = 4;

`ifdef RF_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  logic       clk_regfile = 1'b0;
  logic       reset_n;
  logic       rd_req, wr_req;
  logic [2:0] rd_addr_a, rd_addr_b, wr_addr;
  logic [7:0] wr_data;
  logic       rd_ack, wr_ack, rf_en, rf_we, busy;
  logic [7:0] rd_data_a, rd_data_b, rf_wdata, rf_rdata;
  logic [2:0] rf_addr;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [7:0]  mem    [8];
  logic [7:0]  shadow [8];
  logic [31:0] grant_seq;

  regfile_port_arbiter dut (
    .clk_regfile(clk_regfile), .reset_n(reset_n),
    .rd_req(rd_req), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .rd_ack(rd_ack),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .rf_en(rf_en), .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata), .busy(busy)
  );

  always #5 clk_regfile = ~clk_regfile;

  function automatic logic [7:0] model_init(input int i);
    return (i == 0) ? 8'hFF : 8'(i * 17);
  endfunction

  function automatic logic [7:0] exp_rd(input logic [2:0] a);
    return (ZERO_REG && a == 3'd0) ? 8'h00 : shadow[a];
  endfunction

  // Single-port RF model: synchronous write, read data returned one cycle after the strobe.
  always @(posedge clk_regfile or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 8; i++) mem[i] <= model_init(i);
      rf_rdata <= 8'h00;
    end else begin
      if (rf_en && rf_we) mem[rf_addr] <= rf_wdata;
      rf_rdata <= (rf_en && !rf_we) ? mem[rf_addr] : 8'($urandom);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_regfile);
  endtask

  task automatic wait_ack(input bit is_rd, input int exp_lat, input string tag);
    int n = 0;
    while (!(is_rd ? rd_ack : wr_ack) && n < 32) begin
      step();
      n++;
    end
    check(tag, 32'(n), 32'(exp_lat));
  endtask

  task automatic do_write(input logic [2:0] a, input logic [7:0] d);
    bit supp = ZERO_REG && (a == 3'd0);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    step();
    check("wr_rf_en",    32'(rf_en),    32'(!supp));
    check("wr_rf_we",    32'(rf_we),    32'(!supp));
    check("wr_rf_addr",  32'(rf_addr),  supp ? 32'h0 : 32'(a));
    check("wr_rf_wdata", 32'(rf_wdata), supp ? 32'h0 : 32'(d));
    step();
    check("wr_ack_rise", 32'(wr_ack), 32'h1);
    check("wr_idle_en",  32'(rf_en),  32'h0);
    step();
    check("wr_ack_hold", 32'(wr_ack), 32'h1);
    wr_req = 1'b0;
    step();
    check("wr_ack_drop", 32'(wr_ack), 32'h0);
    check("wr_busy_end", 32'(busy),   32'h0);
    if (!supp) shadow[a] = d;
  endtask

  task automatic do_read(input logic [2:0] a, input logic [2:0] b);
    rd_req = 1'b1; rd_addr_a = a; rd_addr_b = b;
    wait_ack(1'b1, 4, "rd_latency");
    check("rd_data_a", 32'(rd_data_a), 32'(exp_rd(a)));
    check("rd_data_b", 32'(rd_data_b), 32'(exp_rd(b)));
    rd_req = 1'b0;
    step();
    check("rd_ack_drop", 32'(rd_ack),    32'h0);
    check("rd_hold_a",   32'(rd_data_a), 32'(exp_rd(a)));
  endtask

  // Drives both handshakes; a read may wait behind at most STARVE_MAX write acks.
  task automatic run_traffic(input int n_wr, input int n_rd, input bit gaps, input int budget);
    int cyc = 0;
    int wr_left = n_wr;
    int rd_left = n_rd;
    int wr_since_rd = 0;
    grant_seq = '0;
    while ((wr_left > 0 || rd_left > 0 || rd_req || wr_req || rd_ack || wr_ack) && cyc < budget) begin
      step();
      cyc++;
      if (wr_req && wr_ack) begin
        if (!(ZERO_REG && wr_addr == 3'd0)) shadow[wr_addr] = wr_data;
        if (rd_req) wr_since_rd++;
        grant_seq = {grant_seq[30:0], 1'b1};
        wr_req = 1'b0;
        wr_left--;
      end
      if (rd_req && rd_ack) begin
        check("trf_rd_a",   32'(rd_data_a), 32'(exp_rd(rd_addr_a)));
        check("trf_rd_b",   32'(rd_data_b), 32'(exp_rd(rd_addr_b)));
        check("trf_starve", 32'(wr_since_rd <= STARVE_MAX), 32'h1);
        grant_seq = {grant_seq[30:0], 1'b0};
        rd_req = 1'b0;
        rd_left--;
      end
      if (!wr_req && !wr_ack && wr_left > 0 && (!gaps || $urandom_range(2) == 0)) begin
        wr_req = 1'b1; wr_addr = 3'($urandom_range(7)); wr_data = 8'($urandom);
      end
      if (!rd_req && !rd_ack && rd_left > 0 && (!gaps || $urandom_range(3) == 0)) begin
        rd_req = 1'b1; rd_addr_a = 3'($urandom_range(7)); rd_addr_b = 3'($urandom_range(7));
        wr_since_rd = 0;
      end
    end
    check("trf_in_budget", 32'(cyc < budget), 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) shadow[i] = model_init(i);
    reset_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; wr_data = '0;
    step(); step();
    reset_n = 1'b1;
    step();
    check("rst_busy",   32'(busy),      32'h0);
    check("rst_rf_en",  32'(rf_en),     32'h0);
    check("rst_acks",   32'({rd_ack, wr_ack}), 32'h0);
    check("rst_rddata", 32'(rd_data_a), 32'h0);

    // Reset landing in RD_B, then the held request restarts a full read.
    rd_req = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd4;
    step(); step();
    check("rdb_busy",  32'(busy),    32'h1);
    check("rdb_addr",  32'(rf_addr), 32'h4);
    reset_n = 1'b0;
    #1;
    check("mid_rst_outs", 32'({rf_en, rf_we, rd_ack, wr_ack, busy}), 32'h0);
    check("mid_rst_addr", 32'(rf_addr), 32'h0);
    step();
    reset_n = 1'b1;
    wait_ack(1'b1, 4, "restart_latency");
    check("restart_a", 32'(rd_data_a), 32'(exp_rd(3'd3)));
    check("restart_b", 32'(rd_data_b), 32'(exp_rd(3'd4)));
    rd_req = 1'b0;
    step();

    do_write(3'd3, 8'h5A);
    do_write(3'd4, 8'hC3);
    do_read(3'd3, 3'd4);
    check("rd_5a", 32'(rd_data_a), 32'h5A);

    // Same-edge read and write to the same register: the read sees the new value.
    rd_req = 1'b1; rd_addr_a = 3'd3; rd_addr_b = 3'd4;
    wr_req = 1'b1; wr_addr = 3'd3; wr_data = 8'h77;
    step();
    check("raw_wr_first", 32'({rf_en, rf_we, rf_addr}), 32'({2'b11, 3'd3}));
    step();
    check("raw_wr_ack", 32'(wr_ack), 32'h1);
    wr_req = 1'b0;
    shadow[3] = 8'h77;
    wait_ack(1'b1, 5, "raw_rd_latency");
    check("raw_rd_a", 32'(rd_data_a), 32'h77);
    check("raw_rd_b", 32'(rd_data_b), 32'hC3);
    rd_req = 1'b0;
    step();

    // Read dropped early: the access still completes and the ack lasts one cycle.
    rd_req = 1'b1; rd_addr_a = 3'd2; rd_addr_b = 3'd3;
    step();
    rd_req = 1'b0;
    wait_ack(1'b1, 3, "misuse_latency");
    check("misuse_a", 32'(rd_data_a), 32'(exp_rd(3'd2)));
    step();
    check("misuse_ack_drop", 32'(rd_ack), 32'h0);

    // Back-to-back writes with a read held: four writes, the read, then the rest.
    run_traffic(6, 1, 1'b0, 400);
    check("starve_order", grant_seq, 32'b1111011);

    // Register 0 behaviour (hardwired zero only when the feature is built in).
    do_write(3'd0, 8'hAB);
    do_read(3'd0, 3'd3);

    run_traffic(40, 25, 1'b1, 4000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
